rv32i_ctrl_alu: RTL and testbench

Combinational RV32I instruction-field decoder fused with the 32-bit integer ALU of the single-cycle CPU. It turns opcode/funct fields into datapath control (immediate type, register write, branch type, memory op, ALU operand selects and ALU op), and executes that ALU op on the operands the CPU muxes in. One sticky register records any unsupported encoding for debug.

---
 rtl/rv32i_ctrl_alu_if.sv | 34 +++
 rtl/rv32i_ctrl_alu.sv | 178 +++++++++++++++++
 tb/tb_rv32i_ctrl_alu.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_ctrl_alu_if.sv
// Decoder/ALU bus: instruction fields and operands in, datapath control and ALU result out.
interface rv32i_ctrl_alu_if;
    logic [6:0]  op;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [2:0]  ExtOP;
    logic        RegWr;
    logic [2:0]  Branch;
    logic        MemtoReg;
    logic        MemWr;
    logic [2:0]  MemOP;
    logic        ALUAsrc;
    logic [1:0]  ALUBsrc;
    logic [3:0]  ALUctr;
    logic [31:0] aluresult;
    logic        less;
    logic        zero;
    logic        illegal;
    logic        illegal_seen;

    modport master (
        output op, func3, func7, dataa, datab,
        input  ExtOP, RegWr, Branch, MemtoReg, MemWr, MemOP, ALUAsrc, ALUBsrc,
               ALUctr, aluresult, less, zero, illegal, illegal_seen
    );

    modport slave (
        input  op, func3, func7, dataa, datab,
        output ExtOP, RegWr, Branch, MemtoReg, MemWr, MemOP, ALUAsrc, ALUBsrc,
               ALUctr, aluresult, less, zero, illegal, illegal_seen
    );
endinterface

// File: rtl/rv32i_ctrl_alu.sv
// RV32I control decoder fused with the integer ALU; one sticky flag latches any
// unsupported encoding for debug.
module rv32i_ctrl_alu (
    input  logic            clock,
    input  logic            reset,
    rv32i_ctrl_alu_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned SHW  = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;
    localparam logic [3:0] ALU_COPYB = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_U = 3'b001;
    localparam logic [2:0] EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    localparam logic [1:0] BSRC_BUSB = 2'b00;
    localparam logic [1:0] BSRC_IMM  = 2'b01;
    localparam logic [1:0] BSRC_FOUR = 2'b10;

    logic [2:0]      ext_op;
    logic            reg_wr;
    logic [2:0]      branch;
    logic            mem_to_reg;
    logic            mem_wr;
    logic [2:0]      mem_op;
    logic            a_src;
    logic [1:0]      b_src;
    logic [3:0]      alu_ctr;
    logic [3:0]      arith_ctr;
    logic            illegal;
    logic [XLEN-1:0] result;
    logic            less;
    logic [SHW-1:0]  shamt;
    logic            seen;
    logic            unused_func7;

    assign unused_func7 = ^{bus.func7[6], bus.func7[4:0]};

    // OP/OP-IMM func3 mapping; only register-register add can become sub.
    always_comb begin
        arith_ctr = ALU_ADD;
        unique case (bus.func3)
            3'b000:  arith_ctr = (bus.op == OPC_OP && bus.func7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_ctr = ALU_SLL;
            3'b010:  arith_ctr = ALU_SLT;
            3'b011:  arith_ctr = ALU_SLTU;
            3'b100:  arith_ctr = ALU_XOR;
            3'b101:  arith_ctr = bus.func7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  arith_ctr = ALU_OR;
            default: arith_ctr = ALU_AND;
        endcase
    end

    always_comb begin
        ext_op     = EXT_I;
        reg_wr     = 1'b0;
        branch     = 3'b000;
        mem_to_reg = 1'b0;
        mem_wr     = 1'b0;
        mem_op     = 3'b000;
        a_src      = 1'b0;
        b_src      = BSRC_BUSB;
        alu_ctr    = ALU_ADD;
        illegal    = 1'b0;
        unique case (bus.op)
            OPC_LUI: begin
                ext_op = EXT_U; reg_wr = 1'b1; b_src = BSRC_IMM; alu_ctr = ALU_COPYB;
            end
            OPC_AUIPC: begin
                ext_op = EXT_U; reg_wr = 1'b1; a_src = 1'b1; b_src = BSRC_IMM;
            end
            OPC_JAL: begin
                ext_op = EXT_J; reg_wr = 1'b1; branch = 3'b001; a_src = 1'b1; b_src = BSRC_FOUR;
            end
            OPC_JALR: begin
                reg_wr = 1'b1; branch = 3'b010; a_src = 1'b1; b_src = BSRC_FOUR;
                illegal = (bus.func3 != 3'b000);
            end
            OPC_BRANCH: begin
                ext_op = EXT_B;
                unique case (bus.func3)
                    3'b000:  begin branch = 3'b100; alu_ctr = ALU_SUB;  end
                    3'b001:  begin branch = 3'b101; alu_ctr = ALU_SUB;  end
                    3'b100:  begin branch = 3'b110; alu_ctr = ALU_SLT;  end
                    3'b101:  begin branch = 3'b111; alu_ctr = ALU_SLT;  end
                    3'b110:  begin branch = 3'b110; alu_ctr = ALU_SLTU; end
                    3'b111:  begin branch = 3'b111; alu_ctr = ALU_SLTU; end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                reg_wr = 1'b1; mem_to_reg = 1'b1; b_src = BSRC_IMM; mem_op = bus.func3;
                illegal = (bus.func3 == 3'b011) || (bus.func3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                ext_op = EXT_S; mem_wr = 1'b1; b_src = BSRC_IMM; mem_op = bus.func3;
                illegal = (bus.func3[2] || bus.func3 == 3'b011);
            end
            OPC_OPIMM: begin
                reg_wr = 1'b1; b_src = BSRC_IMM; alu_ctr = arith_ctr;
            end
            OPC_OP: begin
                reg_wr = 1'b1; alu_ctr = arith_ctr;
            end
            default: illegal = 1'b1;
        endcase
        // An unsupported encoding must never write state or redirect the PC.
        if (illegal) begin
            ext_op = EXT_I; reg_wr = 1'b0; branch = 3'b000; mem_to_reg = 1'b0;
            mem_wr = 1'b0; mem_op = 3'b000; a_src = 1'b0; b_src = BSRC_BUSB;
            alu_ctr = ALU_ADD;
        end
    end

    assign shamt = bus.datab[SHW-1:0];
    assign less  = alu_ctr[3] ? (bus.dataa < bus.datab)
                              : ($signed(bus.dataa) < $signed(bus.datab));

    always_comb begin
        result = '0;
        unique case (alu_ctr)
            ALU_ADD:            result = bus.dataa + bus.datab;
            ALU_SUB:            result = bus.dataa - bus.datab;
            ALU_SLL:            result = bus.dataa << shamt;
            ALU_SLT, ALU_SLTU:  result = {(XLEN-1)'(0), less};
            ALU_COPYB:          result = bus.datab;
            ALU_XOR:            result = bus.dataa ^ bus.datab;
            ALU_SRL:            result = bus.dataa >> shamt;
            ALU_SRA:            result = XLEN'($signed(bus.dataa) >>> shamt);
            ALU_OR:             result = bus.dataa | bus.datab;
            ALU_AND:            result = bus.dataa & bus.datab;
            default:            result = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       seen <= 1'b0;
        else if (illegal) seen <= 1'b1;
    end

    assign bus.ExtOP        = ext_op;
    assign bus.RegWr        = reg_wr;
    assign bus.Branch       = branch;
    assign bus.MemtoReg     = mem_to_reg;
    assign bus.MemWr        = mem_wr;
    assign bus.MemOP        = mem_op;
    assign bus.ALUAsrc      = a_src;
    assign bus.ALUBsrc      = b_src;
    assign bus.ALUctr       = alu_ctr;
    assign bus.aluresult    = result;
    assign bus.less         = less;
    assign bus.zero         = (result == '0);
    assign bus.illegal      = illegal;
    assign bus.illegal_seen = seen;
endmodule

// File: tb/tb_rv32i_ctrl_alu.sv
// Bench for rv32i_ctrl_alu: directed vector table, sticky-flag sequence and
// randomized encodings against an instruction-level reference model.
module tb_rv32i_ctrl_alu;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BR = 7'b1100011, LOAD = 7'b0000011,
                           STORE = 7'b0100011, OPIMM = 7'b0010011, OP = 7'b0110011;

    typedef struct packed {
        logic [2:0]  ext_op;
        logic        reg_wr;
        logic [2:0]  branch;
        logic        mem_to_reg;
        logic        mem_wr;
        logic [2:0]  mem_op;
        logic        a_src;
        logic [1:0]  b_src;
        logic [3:0]  alu_ctr;
        logic [31:0] result;
        logic        less;
        logic        zero;
        logic        illegal;
    } out_t;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        out_t        exp;
    } vec_t;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    out_t obs;
    vec_t vecs[21];

    rv32i_ctrl_alu_if bus ();

    rv32i_ctrl_alu dut (.clock(clock), .reset(reset), .bus(bus.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign obs = {bus.ExtOP, bus.RegWr, bus.Branch, bus.MemtoReg, bus.MemWr, bus.MemOP,
                  bus.ALUAsrc, bus.ALUBsrc, bus.ALUctr, bus.aluresult, bus.less,
                  bus.zero, bus.illegal};

    function automatic out_t ctl(int ext, int rw, int br, int m2r, int mw, int mop, int asrc,
                                 int bsrc, int ctr, logic [31:0] res, int lt, int z, int ill);
        out_t o;
        o.ext_op = 3'(ext); o.reg_wr = 1'(rw); o.branch = 3'(br); o.mem_to_reg = 1'(m2r);
        o.mem_wr = 1'(mw); o.mem_op = 3'(mop); o.a_src = 1'(asrc); o.b_src = 2'(bsrc);
        o.alu_ctr = 4'(ctr); o.result = res; o.less = 1'(lt); o.zero = 1'(z);
        o.illegal = 1'(ill);
        return o;
    endfunction

    // Reference: classify the instruction, pick its ALU operation, then evaluate arithmetically.
    function automatic out_t model(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                   logic [31:0] a, logic [31:0] b);
        logic [3:0] arith [8];
        logic [2:0] bkind [8];
        out_t       o;
        bit         ok;
        logic [31:0] r;
        int         sh;
        arith = '{4'h0, 4'h1, 4'h2, 4'hA, 4'h4, 4'h5, 4'h6, 4'h7};
        bkind = '{3'd4, 3'd5, 3'd0, 3'd0, 3'd6, 3'd7, 3'd6, 3'd7};
        o  = '0;
        ok = 1'b1;
        if (op == LUI) begin
            o.ext_op = 3'd1; o.reg_wr = 1'b1; o.b_src = 2'd1; o.alu_ctr = 4'h3;
        end else if (op == AUIPC) begin
            o.ext_op = 3'd1; o.reg_wr = 1'b1; o.a_src = 1'b1; o.b_src = 2'd1;
        end else if (op == JAL || op == JALR) begin
            o.ext_op = (op == JAL) ? 3'd4 : 3'd0;
            o.branch = (op == JAL) ? 3'd1 : 3'd2;
            o.reg_wr = 1'b1; o.a_src = 1'b1; o.b_src = 2'd2;
            ok = (op == JAL) || (f3 == 3'd0);
        end else if (op == BR) begin
            o.ext_op = 3'd3;
            o.branch = bkind[f3];
            ok = (f3 != 3'd2) && (f3 != 3'd3);
            if (f3 < 3'd2)       o.alu_ctr = 4'h8;
            else if (f3 < 3'd6)  o.alu_ctr = 4'h2;
            else                 o.alu_ctr = 4'hA;
        end else if (op == LOAD) begin
            o.reg_wr = 1'b1; o.mem_to_reg = 1'b1; o.b_src = 2'd1; o.mem_op = f3;
            ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end else if (op == STORE) begin
            o.ext_op = 3'd2; o.mem_wr = 1'b1; o.b_src = 2'd1; o.mem_op = f3;
            ok = (f3 <= 3'd2);
        end else if (op == OP || op == OPIMM) begin
            o.reg_wr = 1'b1;
            o.b_src  = (op == OPIMM) ? 2'd1 : 2'd0;
            o.alu_ctr = arith[f3];
            if (f7[5] && (f3 == 3'd5 || (f3 == 3'd0 && op == OP)))
                o.alu_ctr = o.alu_ctr + 4'h8;
        end else begin
            ok = 1'b0;
        end
        if (!ok) begin
            o = '0;
            o.illegal = 1'b1;
        end
        o.less = o.alu_ctr[3] ? (a < b) : ($signed(a) < $signed(b));
        sh = int'(b % 32);
        case (o.alu_ctr)
            4'h0: r = a + b;
            4'h8: r = a - b;
            4'h1: r = a << sh;
            4'h2, 4'hA: r = o.less ? 32'd1 : 32'd0;
            4'h3: r = b;
            4'h4: r = a ^ b;
            4'h5: r = a >> sh;
            4'hD: r = 32'($signed(a) >>> sh);
            4'h6: r = a | b;
            4'h7: r = a & b;
            default: r = 32'd0;
        endcase
        o.result = r;
        o.zero   = (r == 32'd0);
        return o;
    endfunction

    task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        bus.op = op; bus.func3 = f3; bus.func7 = f7; bus.dataa = a; bus.datab = b;
    endtask

    task automatic check_out(input string name, input out_t exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: op=%b f3=%b got %h (res %h) want %h (res %h)", name,
                     bus.op, bus.func3, obs, obs.result, exp, exp.result);
        end
    endtask

    task automatic check_seen(input string name, input logic exp);
        checks++;
        if (bus.illegal_seen !== exp) begin
            failures++;
            $display("FAIL %s: illegal_seen got %b want %b", name, bus.illegal_seen, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{OP,    3'd0, 7'h00, 32'd7,        32'd5,        ctl(0,1,0,0,0,0,0,0,'h0,32'd12,0,0,0)};
        vecs[1]  = '{OP,    3'd0, 7'h20, 32'd7,        32'd5,        ctl(0,1,0,0,0,0,0,0,'h8,32'd2,0,0,0)};
        vecs[2]  = '{OP,    3'd5, 7'h20, 32'h80000000, 32'd4,        ctl(0,1,0,0,0,0,0,0,'hD,32'hF8000000,0,0,0)};
        vecs[3]  = '{OP,    3'd5, 7'h00, 32'h80000000, 32'd4,        ctl(0,1,0,0,0,0,0,0,'h5,32'h08000000,1,0,0)};
        vecs[4]  = '{OP,    3'd3, 7'h00, 32'd1,        32'hFFFFFFFF, ctl(0,1,0,0,0,0,0,0,'hA,32'd1,1,0,0)};
        vecs[5]  = '{BR,    3'd4, 7'h00, 32'hFFFFFFFF, 32'd1,        ctl(3,0,6,0,0,0,0,0,'h2,32'd1,1,0,0)};
        vecs[6]  = '{BR,    3'd6, 7'h00, 32'hFFFFFFFF, 32'd1,        ctl(3,0,6,0,0,0,0,0,'hA,32'd0,0,1,0)};
        vecs[7]  = '{BR,    3'd0, 7'h00, 32'h1234,     32'h1234,     ctl(3,0,4,0,0,0,0,0,'h8,32'd0,0,1,0)};
        vecs[8]  = '{BR,    3'd5, 7'h00, 32'd5,        32'd5,        ctl(3,0,7,0,0,0,0,0,'h2,32'd0,0,1,0)};
        vecs[9]  = '{LUI,   3'd0, 7'h00, 32'h11,       32'hABCDE000, ctl(1,1,0,0,0,0,0,1,'h3,32'hABCDE000,0,0,0)};
        vecs[10] = '{LOAD,  3'd2, 7'h00, 32'h100,      32'd8,        ctl(0,1,0,1,0,2,0,1,'h0,32'h108,0,0,0)};
        vecs[11] = '{STORE, 3'd0, 7'h00, 32'h200,      32'hFFFFFFFC, ctl(2,0,0,0,1,0,0,1,'h0,32'h1FC,0,0,0)};
        vecs[12] = '{7'h7F, 3'd0, 7'h00, 32'd3,        32'd4,        ctl(0,0,0,0,0,0,0,0,'h0,32'd7,1,0,1)};
        vecs[13] = '{JAL,   3'd0, 7'h00, 32'h1000,     32'd4,        ctl(4,1,1,0,0,0,1,2,'h0,32'h1004,0,0,0)};
        vecs[14] = '{JALR,  3'd0, 7'h00, 32'h1000,     32'd4,        ctl(0,1,2,0,0,0,1,2,'h0,32'h1004,0,0,0)};
        vecs[15] = '{JALR,  3'd1, 7'h00, 32'h1000,     32'd4,        ctl(0,0,0,0,0,0,0,0,'h0,32'h1004,0,0,1)};
        vecs[16] = '{AUIPC, 3'd0, 7'h00, 32'h1000,     32'h5000,     ctl(1,1,0,0,0,0,1,1,'h0,32'h6000,1,0,0)};
        vecs[17] = '{OPIMM, 3'd0, 7'h20, 32'd10,       32'd3,        ctl(0,1,0,0,0,0,0,1,'h0,32'd13,0,0,0)};
        vecs[18] = '{BR,    3'd2, 7'h00, 32'd1,        32'd2,        ctl(0,0,0,0,0,0,0,0,'h0,32'd3,1,0,1)};
        vecs[19] = '{LOAD,  3'd3, 7'h00, 32'd0,        32'd0,        ctl(0,0,0,0,0,0,0,0,'h0,32'd0,0,1,1)};
        vecs[20] = '{OPIMM, 3'd5, 7'h20, 32'hF0000000, 32'h404,      ctl(0,1,0,0,0,0,0,1,'hD,32'hFF000000,0,0,0)};

        reset = 1'b0;
        apply(OP, 3'd0, 7'h00, 32'd0, 32'd0);
        #1 check_seen("reset_state", 1'b0);

        // Combinational outputs must be live even while reset is held low.
        for (int i = 0; i < 21; i++) begin
            @(negedge clock);
            apply(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
            #1 check_out($sformatf("vec%0d", i), vecs[i].exp);
        end
        @(negedge clock);
        check_seen("seen_held_in_reset", 1'b0);

        apply(OP, 3'd0, 7'h00, 32'd1, 32'd1);
        reset = 1'b1;
        @(posedge clock); #1 check_seen("seen_after_legal", 1'b0);
        @(negedge clock);
        apply(7'h7F, 3'd0, 7'h00, 32'd0, 32'd0);
        @(posedge clock); #1 check_seen("seen_set", 1'b1);
        @(negedge clock);
        apply(OP, 3'd0, 7'h00, 32'd1, 32'd1);
        @(posedge clock); #1 check_seen("seen_sticky", 1'b1);
        #2 reset = 1'b0;
        #1 check_seen("seen_async_clear", 1'b0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 400; i++) begin
            logic [6:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [6:0]  opcodes [9];
            opcodes = '{LUI, AUIPC, JAL, JALR, BR, LOAD, STORE, OPIMM, OP};
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : opcodes[$urandom_range(0, 8)];
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
            @(negedge clock);
            apply(op, 3'($urandom), 7'($urandom), a, b);
            #1 check_out($sformatf("rand%0d", i), model(bus.op, bus.func3, bus.func7, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
